// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp 26-bit float datapath: field layout,
// saturation pattern and the divider control states.
package sfp_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned SFP_W    = 26;
    localparam int unsigned SIGN_BIT = 25;
    localparam int unsigned EXP_MSB  = 24;
    localparam int unsigned EXP_LSB  = 17;
    localparam int unsigned EXP_W    = EXP_MSB - EXP_LSB + 1;
    localparam int unsigned FRAC_W   = 17;
    localparam int unsigned MANT_W   = 18;
    localparam int unsigned EXPI_W   = 11;

    localparam logic [FRAC_W-1:0] SFP_SAT_MAG = 17'h1FFFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } sfp_t;

    typedef enum logic [2:0] {IDLE, NORM, DIV, PACK, OUT} state_t;

endpackage

// File: rtl/sfp_lzc.sv
// Leading-one normaliser: places the leading one of an 18-bit magnitude at
// bit 16 and reports the matching signed exponent adjustment.
module sfp_lzc
    import sfp_pkg::*;
(
    input  logic [17:0] mag,
    output logic [16:0] norm_c,
    output logic [10:0] adj_c
);

    logic [4:0] lead;
    logic [4:0] shamt;

    always_comb begin
        lead = '0;
        for (int i = 0; i < int'(FRAC_W); i++) begin
            if (mag[i]) lead = 5'(i);
        end
        shamt = 5'd16 - lead;
        // Only 2^17 can reach bit 17; it needs a right shift instead.
        if (mag[MANT_W-1]) begin
            norm_c = mag[17:1];
            adj_c  = 11'd1;
        end else begin
            norm_c = mag[16:0] << shamt;
            adj_c  = 11'd0 - 11'(shamt);
        end
    end

endmodule

// File: rtl/sfp_div.sv
// Iterative sfp divider: normalise, 18-step restoring divide, pack with
// divide-by-zero / overflow / underflow handling. One result per 21 cycles.
module sfp_div #(
    parameter int unsigned EXP_BIAS = sfp_pkg::EXP_BIAS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [25:0] i_da,
    input  logic [25:0] i_db,
    output logic        o_rdy,
    output logic        o_vld,
    output logic [25:0] o_do,
    output logic        o_dz,
    output logic        o_ovf,
    output logic        o_unf
);
    import sfp_pkg::*;

    state_t      state, state_nxt;
    logic        accept;
    sfp_t        da_q, db_q;
    logic        sign_q, a_zero, b_zero;
    logic [16:0] nb;
    logic [10:0] ea, eb;
    logic [18:0] rem, diff;
    logic [17:0] quo;
    logic [4:0]  cnt;
    logic        ge;

    logic [17:0] ma, mb, mag_a, mag_b;
    logic [16:0] norm_a, norm_b;
    logic [10:0] adj_a, adj_b;

    logic [10:0] exp_r;
    logic [16:0] mag_r;
    logic [17:0] mant_r;
    sfp_t        res, sat_w;
    logic        dz_r, ovf_r, unf_r;

    assign ma    = {da_q.sign, da_q.frac};
    assign mb    = {db_q.sign, db_q.frac};
    assign mag_a = ma[17] ? 18'(-ma) : ma;
    assign mag_b = mb[17] ? 18'(-mb) : mb;

    sfp_lzc u_lzc_a (.mag(mag_a), .norm_c(norm_a), .adj_c(adj_a));
    sfp_lzc u_lzc_b (.mag(mag_b), .norm_c(norm_b), .adj_c(adj_b));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req) begin
                    accept    = 1'b1;
                    state_nxt = NORM;
                end
            end
            NORM: state_nxt = DIV;
            DIV:  if (cnt == 5'(MANT_W - 1)) state_nxt = PACK;
            PACK: state_nxt = OUT;
            OUT: begin
                if (i_req) begin
                    accept    = 1'b1;
                    state_nxt = NORM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Restoring step: remainder stays below 2^18, so bit 18 of diff is the borrow.
    assign diff = rem - {2'b00, nb};
    assign ge   = ~diff[18];

    always_comb begin
        exp_r  = ea - eb + 11'(EXP_BIAS) - (quo[17] ? 11'd0 : 11'd1);
        mag_r  = quo[17] ? quo[17:1] : quo[16:0];
        mant_r = sign_q ? 18'(-{1'b0, mag_r}) : {1'b0, mag_r};
        sat_w  = '{sign: sign_q, exp: '1, frac: SFP_SAT_MAG};
        res    = '{sign: mant_r[17], exp: exp_r[7:0], frac: mant_r[16:0]};
        dz_r   = 1'b0;
        ovf_r  = 1'b0;
        unf_r  = 1'b0;
        if (b_zero) begin
            dz_r = 1'b1;
            res  = sat_w;
        end else if (a_zero) begin
            res = '0;
        end else if (!exp_r[10] && exp_r[9:8] != 2'b00) begin
            ovf_r = 1'b1;
            res   = sat_w;
        end else if (exp_r[10]) begin
            unf_r = 1'b1;
            res   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rdy  <= 1'b1;
            o_vld  <= 1'b0;
            o_do   <= '0;
            o_dz   <= 1'b0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
            da_q   <= '0;
            db_q   <= '0;
            sign_q <= 1'b0;
            a_zero <= 1'b0;
            b_zero <= 1'b0;
            nb     <= '0;
            ea     <= '0;
            eb     <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
        end else begin
            o_rdy <= (state_nxt == IDLE) || (state_nxt == OUT);
            o_vld <= (state_nxt == OUT);
            if (accept) begin
                da_q <= i_da;
                db_q <= i_db;
            end
            case (state)
                NORM: begin
                    sign_q <= da_q.sign ^ db_q.sign;
                    a_zero <= (ma == '0);
                    b_zero <= (mb == '0);
                    nb     <= norm_b;
                    ea     <= 11'(da_q.exp) + adj_a;
                    eb     <= 11'(db_q.exp) + adj_b;
                    rem    <= {2'b00, norm_a};
                    quo    <= '0;
                    cnt    <= '0;
                end
                DIV: begin
                    rem <= ge ? {diff[17:0], 1'b0} : {rem[17:0], 1'b0};
                    quo <= {quo[16:0], ge};
                    cnt <= cnt + 5'd1;
                end
                PACK: begin
                    o_do  <= res;
                    o_dz  <= dz_r;
                    o_ovf <= ovf_r;
                    o_unf <= unf_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_div.sv
// Self-checking bench for sfp_div: directed vector table, randomized
// operands against a value-level reference, and handshake/reset sequences.
module tb_sfp_div;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic [25:0] i_da, i_db;
    logic        o_rdy, o_vld, o_dz, o_ovf, o_unf;
    logic [25:0] o_do;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    sfp_div dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_da(i_da), .i_db(i_db),
        .o_rdy(o_rdy), .o_vld(o_vld), .o_do(o_do), .o_dz(o_dz),
        .o_ovf(o_ovf), .o_unf(o_unf)
    );

    typedef struct {
        logic [25:0] da;
        logic [25:0] db;
        logic [25:0] q;
        logic        dz;
        logic        ovf;
        logic        unf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Quotient from operand values: find the scale that puts the truncated
    // magnitude in [2^16, 2^17), then derive the biased exponent.
    function automatic logic [28:0] model(input logic [25:0] a, input logic [25:0] b);
        logic signed [17:0] sa, sb;
        longint am, bm, mag;
        int s, e;
        logic sgn;
        logic [17:0] mant;
        sa  = {a[25], a[16:0]};
        sb  = {b[25], b[16:0]};
        am  = (sa < 0) ? -longint'(sa) : longint'(sa);
        bm  = (sb < 0) ? -longint'(sb) : longint'(sb);
        sgn = a[25] ^ b[25];
        if (bm == 0) return {sgn, 8'hFF, 17'h1FFFF, 3'b100};
        if (am == 0) return 29'd0;
        s   = 0;
        mag = 0;
        for (int t = 0; t <= 40; t++) begin
            mag = (am << t) / (bm << 1);
            if (mag >= 65536 && mag < 131072) begin
                s = t - 1;
                break;
            end
        end
        e = 143 + int'(a[24:17]) - int'(b[24:17]) - s;
        if (e > 255) return {sgn, 8'hFF, 17'h1FFFF, 3'b010};
        if (e < 0)   return {26'd0, 3'b001};
        mant = sgn ? 18'(-mag) : 18'(mag);
        return {mant[17], 8'(e), mant[16:0], 3'b000};
    endfunction

    function automatic logic [25:0] rnd_sfp();
        logic [17:0] m;
        logic [7:0]  e;
        m = 18'($urandom);
        if ($urandom_range(0, 7) == 0)      m = '0;
        else if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(0, 17);
        e = ($urandom_range(0, 1) == 1) ? 8'(107 + $urandom_range(0, 40)) : 8'($urandom);
        return {m[17], e, m[16:0]};
    endfunction

    task automatic do_op(input logic [25:0] a, input logic [25:0] b,
                         output logic [28:0] r, output int cyc);
        int guard;
        guard = 0;
        while (!o_rdy && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        i_da  = a;
        i_db  = b;
        i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("rdy_vld_after_accept", 32'({o_rdy, o_vld}), 32'd0);
        cyc = 1;
        while (!o_vld && cyc < 40) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        r = {o_do, o_dz, o_ovf, o_unf};
        chk("rdy_in_vld_cycle", 32'(o_rdy), 32'd1);
    endtask

    vec_t        tbl[15];
    logic [28:0] r;
    int          cyc, pulses;
    logic [25:0] ra, rb;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{26'h1010000, 26'h0FF0000, 26'h1010000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{26'h0FF0000, 26'h3010000, 26'h2FD0000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{26'h0FF0000, 26'h1018000, 26'h0FB5555, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{26'h0FF0000, 26'h0000000, 26'h1FFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{26'h0000000, 26'h0FF0000, 26'h0000000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{26'h1FF0000, 26'h0010000, 26'h1FFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{26'h0010000, 26'h1FF0000, 26'h0000000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{26'h0000000, 26'h0000000, 26'h1FFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{26'h2FF0000, 26'h0000000, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{26'h2FE0000, 26'h0FF0000, 26'h3010000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{26'h0FF0000, 26'h1FD0000, 26'h0010000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{26'h1FF0000, 26'h0FF0000, 26'h1FF0000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{26'h1FF0000, 26'h0FD0000, 26'h1FFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{26'h0FD0000, 26'h1FD0000, 26'h0000000, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{26'h0FE0001, 26'h0FF0000, 26'h0DF0000, 1'b0, 1'b0, 1'b0};

        i_rst = 1'b1;
        i_req = 1'b0;
        i_da  = '0;
        i_db  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_state", 32'({o_rdy, o_vld, o_do, o_dz, o_ovf, o_unf}), 32'({1'b1, 30'd0}));
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        foreach (tbl[i]) begin
            do_op(tbl[i].da, tbl[i].db, r, cyc);
            chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd21);
            chk($sformatf("vec%0d_result", i), 32'(r),
                32'({tbl[i].q, tbl[i].dz, tbl[i].ovf, tbl[i].unf}));
        end

        for (int i = 0; i < 40; i++) begin
            ra = rnd_sfp();
            rb = rnd_sfp();
            do_op(ra, rb, r, cyc);
            chk($sformatf("rnd%0d_latency", i), 32'(cyc), 32'd21);
            chk($sformatf("rnd%0d_%h_%h", i, ra, rb), 32'(r), 32'(model(ra, rb)));
        end

        // A request during the busy window must be dropped, not queued.
        repeat (2) @(posedge i_clk);
        #1;
        i_da  = 26'h1010000;
        i_db  = 26'h0FF0000;
        i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        cyc   = 1;
        while (cyc < 5) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        i_da  = 26'h0FF0000;
        i_db  = 26'h1018000;
        i_req = 1'b1;
        @(posedge i_clk); #1;
        cyc++;
        i_req = 1'b0;
        while (!o_vld && cyc < 40) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        chk("ignored_req_latency", 32'(cyc), 32'd21);
        chk("ignored_req_result", 32'(o_do), 32'h1010000);
        pulses = 0;
        repeat (30) begin
            @(posedge i_clk); #1;
            if (o_vld) pulses++;
        end
        chk("ignored_req_not_queued", 32'(pulses), 32'd0);
        chk("idle_rdy", 32'(o_rdy), 32'd1);

        // Reset in the middle of a divide discards the result.
        i_da  = 26'h0FF0000;
        i_db  = 26'h1018000;
        i_req = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("midop_reset_state", 32'({o_rdy, o_vld, o_do}), 32'({1'b1, 27'd0}));
        pulses = 0;
        repeat (30) begin
            @(posedge i_clk); #1;
            if (o_vld) pulses++;
        end
        chk("midop_reset_no_vld", 32'(pulses), 32'd0);

        // Back-to-back: next request lands in the o_vld cycle.
        do_op(26'h1010000, 26'h0FF0000, r, cyc);
        chk("b2b_first_result", 32'(r), 32'({26'h1010000, 3'b000}));
        chk("b2b_vld_rdy", 32'({o_vld, o_rdy}), 32'd3);
        do_op(26'h0FF0000, 26'h3010000, r, cyc);
        chk("b2b_second_latency", 32'(cyc), 32'd21);
        chk("b2b_second_result", 32'(r), 32'({26'h2FD0000, 3'b000}));
        repeat (3) @(posedge i_clk);
        #1;
        chk("hold_after_vld", 32'({o_vld, o_do}), 32'({1'b0, 26'h2FD0000}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sfp_div.md
Name: sfp_div

Overview:
Iterative divider for the team's 26-bit sfp float format; it is the inverse operation of sfp_mult.
- Format: o_do/i_d* = {mantissa sign [25], exp [24:17] biased by EXP_BIAS, mantissa low [16:0]}.
- Mantissa M = signed 18-bit {bit25, bits16:0} with 16 fraction bits; value = M/2^16 · 2^(exp−EXP_BIAS).
- Computes da/db one quotient bit per clock behind a ready/request handshake, with divide-by-zero, overflow and underflow flags.
- Sits next to sfp_mult in the sfp datapath (normalisation/scaling stages).

Parameters:
EXP_BIAS, 127, exponent bias added back to the exponent difference.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  1  request; accepted only when o_rdy=1.
- i_da  in  26  dividend, sfp format.
- i_db  in  26  divisor, sfp format.
- o_rdy  out  1  block idle, can accept i_req.
- o_vld  out  1  one-cycle pulse, o_do and flags valid.
- o_do  out  26  quotient, sfp format, held until next o_vld.
- o_dz  out  1  divide by zero; valid with o_vld.
- o_ovf  out  1  exponent overflow, saturated; valid with o_vld.
- o_unf  out  1  exponent underflow, flushed to zero; valid with o_vld.

Behaviour:
Reset:
- i_rst=1 at an edge → state IDLE, o_rdy=1, o_vld=0, o_do=0, flags=0.
- Applies mid-operation; the in-flight result is discarded and never presented.

Handshake and timing:
- Accept on the edge where i_req=1 and o_rdy=1.
- i_req while o_rdy=0 is ignored (no queueing).
- o_rdy falls the cycle after accept.
- o_vld pulses exactly 21 cycles after the accept edge.
- o_rdy rises in that same o_vld cycle, so back-to-back requests are allowed.
- Throughput: 1 result per 21 cycles.

States:
- IDLE → NORM on accept.
- NORM, 1 cycle: sign_q = da[25]^db[25].
  - Magnitudes |Ma|, |Mb| are 18-bit unsigned.
  - Each magnitude is normalised so bit16 is the leading one. Left shift by k decrements the exponent by k. Magnitude 2^17 (M=−131072) is right-shifted by 1, exponent +1.
  - Exponents are held as 11-bit signed.
- DIV, 18 cycles: restoring division Q' = floor(Na·2^17 / Nb).
  - 18-bit quotient, MSB first.
  - 19-bit partial remainder.
- PACK, 1 cycle:
  - If Q'[17]=1: mag = Q'[17:1], adj = 0. Else: mag = Q'[16:0], adj = −1. mag is always in [2^16, 2^17).
  - Truncation only, no rounding.
  - e = ea_n − eb_n + EXP_BIAS + adj.
  - Mantissa = sign_q ? −mag : mag, as 18-bit two's complement.
- OUT: o_vld=1 → IDLE (or NORM if a new i_req is accepted this cycle).

Special cases, precedence top-down:
1. Mb=0 → o_dz=1, o_do={sign_q, 8'hFF, 17'h1FFFF}. Covers 0/0.
2. Ma=0 → o_do=0, no flags.
3. e>255 → o_ovf=1, same saturated pattern as o_dz.
4. e<0 → o_unf=1, o_do=0.

Flags are cleared on every o_vld that does not set them. Latency is identical for all cases.

Decomposition:
- Package sfp_pkg: EXP_BIAS, field widths and positions (SIGN_BIT=25, EXP_MSB/LSB=24/17, FRAC_W=17, MANT_W=18), SFP_SAT_MAG=17'h1FFFF, state enum {IDLE, NORM, DIV, PACK, OUT}.
- Sub-module sfp_lzc: combinational 18-bit leading-one detector and shifter, returns shifted magnitude plus signed exponent adjust. Instantiated for da and db.

Test Plan:
- da=26'h1010000 (2.0), db=26'h0FF0000 (1.0) → o_vld at cycle 21 after accept, o_do=26'h1010000, flags 0.
- da=26'h0FF0000 (1.0), db=26'h3010000 (−2.0) → o_do=26'h2FD0000 (−0.5), flags 0.
- da=26'h0FF0000, db=26'h1018000 (3.0) → o_do=26'h0FB5555, truncated 0.3333.
- da=26'h0FF0000, db=0 → o_dz=1, o_do=26'h1FFFFFF. Then da=0, db=26'h0FF0000 → o_do=0, flags 0.
- da exp 255 mant 0x10000 / db exp 0 mant 0x10000 → o_ovf=1, o_do=26'h1FFFFFF. Swapped → o_unf=1, o_do=0.
- Second i_req at cycle 5 is ignored. i_rst=1 at cycle 10 → no o_vld, o_rdy=1 next cycle. Back-to-back request on the o_vld cycle is accepted; its result arrives 21 cycles later.
